// File: rtl/mem_pkg.sv
// Shared configuration for the memory stage: widths, op codes, boolean
// constants, and small helpers that classify ops and extend loaded data.
package mem_pkg;

  localparam int OpLen      = 8;
  localparam int RegLen     = 32;
  localparam int AddrLen    = 32;
  localparam int RegAddrLen = 5;

  localparam logic [RegLen-1:0]     ZERO_WORD   = '0;
  localparam logic [RegAddrLen-1:0] RegAddrZero = '0;
  localparam logic                  True        = 1'b1;
  localparam logic                  False       = 1'b0;

  localparam logic [OpLen-1:0] OP_NOP = 8'h00;
  localparam logic [OpLen-1:0] OP_ADD = 8'h01;
  localparam logic [OpLen-1:0] OP_SUB = 8'h02;
  localparam logic [OpLen-1:0] OP_LB  = 8'h10;
  localparam logic [OpLen-1:0] OP_LH  = 8'h11;
  localparam logic [OpLen-1:0] OP_LW  = 8'h12;
  localparam logic [OpLen-1:0] OP_LBU = 8'h13;
  localparam logic [OpLen-1:0] OP_LHU = 8'h14;
  localparam logic [OpLen-1:0] OP_SB  = 8'h20;
  localparam logic [OpLen-1:0] OP_SH  = 8'h21;
  localparam logic [OpLen-1:0] OP_SW  = 8'h22;

  function automatic logic is_load(input logic [OpLen-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OpLen-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_idx(input logic [OpLen-1:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  // Apply the op's width and signedness to the assembled load buffer.
  function automatic logic [RegLen-1:0] load_extend(input logic [OpLen-1:0] op,
                                                    input logic [31:0]      word);
    case (op)
      OP_LB:   return {{24{word[7]}}, word[7:0]};
      OP_LBU:  return {24'b0, word[7:0]};
      OP_LH:   return {{16{word[15]}}, word[15:0]};
      OP_LHU:  return {16'b0, word[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem.sv
// Memory pipeline stage: passes ALU results straight through and sequences
// loads/stores one byte at a time over a handshaked memory-controller port,
// stalling the earlier pipeline until the access completes.
module mem
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegLen-1:0]     rd_data_i,
  input  logic [RegAddrLen-1:0] rd_addr_i,
  input  logic [AddrLen-1:0]    mem_addr_i,
  input  logic [OpLen-1:0]      op_i,
  output logic [RegLen-1:0]     rd_data_o,
  output logic [RegAddrLen-1:0] rd_addr_o,
  output logic                  mem_stall,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [AddrLen-1:0]    mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_ack,
  input  logic [7:0]            mc_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] load_buf;
  logic        is_mem;

  assign is_mem = is_load(op_i) || is_store(op_i);

  // Byte sequencer: advance on each acknowledged byte, collect load data.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      load_buf <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            state    <= BUSY;
            idx      <= 2'd0;
            load_buf <= 32'b0;
          end
        end
        BUSY: begin
          if (mc_ack) begin
            if (is_load(op_i)) load_buf[idx*8 +: 8] <= mc_rdata;
            if (idx == last_idx(op_i)) state <= DONE;
            else                       idx   <= idx + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: pass-through, bus request, or writeback of the load result.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rd_data_o = ZERO_WORD;
    rd_addr_o = RegAddrZero;
    mem_stall = False;
    mc_req    = False;
    mc_we     = False;
    mc_addr   = '0;
    mc_wdata  = 8'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            mem_stall = True;
          end else begin
            rd_data_o = rd_data_i;
            rd_addr_o = rd_addr_i;
          end
        end
        BUSY: begin
          mem_stall = True;
          mc_req    = True;
          mc_we     = is_store(op_i);
          mc_addr   = mem_addr_i + AddrLen'(idx);
          mc_wdata  = rd_data_i[idx*8 +: 8];
        end
        DONE: begin
          if (is_load(op_i)) begin
            rd_data_o = load_extend(op_i, load_buf);
            rd_addr_o = rd_addr_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the memory stage: a vector table of ops run
// through a byte-level memory-controller model, with expected bus requests
// queued when an op is driven and compared as the DUT issues them.
module tb_mem;
  import mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RegLen-1:0]     rd_data_i;
  logic [RegAddrLen-1:0] rd_addr_i;
  logic [AddrLen-1:0]    mem_addr_i;
  logic [OpLen-1:0]      op_i;
  logic [RegLen-1:0]     rd_data_o;
  logic [RegAddrLen-1:0] rd_addr_o;
  logic                  mem_stall;
  logic                  mc_req;
  logic                  mc_we;
  logic [AddrLen-1:0]    mc_addr;
  logic [7:0]            mc_wdata;
  logic                  mc_ack;
  logic [7:0]            mc_rdata;

  int total = 0;
  int bad   = 0;

  mem dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .mem_addr_i(mem_addr_i), .op_i(op_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .mem_stall(mem_stall),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OpLen-1:0]      op;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [RegAddrLen-1:0] rd;
    logic [31:0]           rdata;     // bytes the controller returns, little-endian
    int                    wait_cyc;  // cycles each request waits before ack
    logic [31:0]           exp_data;
    logic [RegAddrLen-1:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  req_t req_q[$];
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int byte_count(input logic [OpLen-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  // Drive one op and act as the memory controller until its result appears.
  task automatic do_op(input vec_t v);
    int   n;
    int   waits;
    int   stalls;
    int   exp_stalls;
    int   bi;
    logic done;
    logic st;
    n  = byte_count(v.op);
    st = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
    exp_stalls = (n == 0) ? 0 : 1 + n * (v.wait_cyc + 1);
    req_q.delete();
    for (int i = 0; i < n; i++)
      req_q.push_back('{addr: v.addr + 32'(i), we: st, wdata: v.wdata[8*i +: 8]});
    @(negedge clk);
    mc_ack     = 1'b0;
    mc_rdata   = 8'h5A;
    op_i       = v.op;
    mem_addr_i = v.addr;
    rd_data_i  = v.wdata;
    rd_addr_i  = v.rd;
    done   = 1'b0;
    waits  = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        mc_ack   = 1'b0;
        mc_rdata = 8'h5A;
      end
      #1;
      if (mc_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(mc_req), 32'd0);
        end else begin
          check("req_addr", mc_addr, req_q[0].addr);
          check("req_we", 32'(mc_we), 32'(req_q[0].we));
          check("req_wdata", 32'(mc_wdata), 32'(req_q[0].wdata));
          if (waits == v.wait_cyc) begin
            bi       = n - req_q.size();
            mc_ack   = 1'b1;
            mc_rdata = v.rdata[8*bi +: 8];
            void'(req_q.pop_front());
            waits = 0;
          end else begin
            waits++;
          end
        end
      end
      if (mem_stall) begin
        stalls++;
      end else begin
        done = 1'b1;
        check("rd_data", rd_data_o, v.exp_data);
        check("rd_addr", 32'(rd_addr_o), 32'(v.exp_rd));
        check("req_low_at_result", 32'(mc_req), 32'd0);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("reqs_left", 32'(req_q.size()), 32'd0);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 32'h0,        32'h12345678, 5'd5,  32'h0,        0, 32'h12345678, 5'd5};
    vecs[1]  = '{OP_LB,  32'h100,      32'h0,        5'd7,  32'h00000080, 3, 32'hFFFFFF80, 5'd7};
    vecs[2]  = '{OP_LBU, 32'h100,      32'h0,        5'd7,  32'h00000080, 3, 32'h00000080, 5'd7};
    vecs[3]  = '{OP_LW,  32'h200,      32'h0,        5'd9,  32'h12345678, 0, 32'h12345678, 5'd9};
    vecs[4]  = '{OP_SH,  32'hFFFFFFFF, 32'hABCDBEEF, 5'd3,  32'h0,        0, 32'h0,        5'd0};
    vecs[5]  = '{OP_LH,  32'h10,       32'h0,        5'd4,  32'h00008001, 1, 32'hFFFF8001, 5'd4};
    vecs[6]  = '{OP_SB,  32'h20,       32'h000000C3, 5'd6,  32'h0,        0, 32'h0,        5'd0};
    vecs[7]  = '{OP_LHU, 32'h30,       32'h0,        5'd8,  32'h0000F00D, 2, 32'h0000F00D, 5'd8};
    vecs[8]  = '{OP_SW,  32'h40,       32'hDEADBEEF, 5'd1,  32'h0,        1, 32'h0,        5'd0};
    vecs[9]  = '{OP_SUB, 32'h0,        32'hCAFEF00D, 5'd31, 32'h0,        0, 32'hCAFEF00D, 5'd31};
    vecs[10] = '{OP_LB,  32'h7,        32'h0,        5'd2,  32'h0000007F, 0, 32'h0000007F, 5'd2};

    // Reset with a live ALU op: all outputs must still be zero.
    rst        = 1'b1;
    mc_ack     = 1'b0;
    mc_rdata   = 8'h00;
    op_i       = OP_ADD;
    rd_data_i  = 32'h12345678;
    rd_addr_i  = 5'd5;
    mem_addr_i = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    check("rst_stall", 32'(mem_stall), 32'h0);
    check("rst_mc_req", 32'(mc_req), 32'h0);
    check("rst_mc_addr", mc_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sweep; entries 5 and 6 run back to back (LH then SB).
    for (int i = 0; i < 11; i++) do_op(vecs[i]);

    // LW interrupted by reset after its second byte is acknowledged.
    @(negedge clk);
    mc_ack = 1'b0; op_i = OP_LW; mem_addr_i = 32'h300; rd_data_i = 32'h0; rd_addr_i = 5'd9;
    #1;
    check("lw_rst_idle_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    #1;
    check("lw_rst_b0_addr", mc_addr, 32'h300);
    mc_ack = 1'b1; mc_rdata = 8'hAA;
    @(negedge clk);
    mc_ack = 1'b0;
    #1;
    check("lw_rst_b1_addr", mc_addr, 32'h301);
    mc_ack = 1'b1; mc_rdata = 8'hBB;
    @(negedge clk);
    mc_ack = 1'b0;
    rst    = 1'b1;
    #1;
    check("lw_rst_req", 32'(mc_req), 32'd0);
    check("lw_rst_stall", 32'(mem_stall), 32'd0);
    check("lw_rst_data", rd_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b0; op_i = OP_ADD; rd_data_i = 32'h0000BEEF; rd_addr_i = 5'd11;
    #1;
    check("post_rst_req", 32'(mc_req), 32'd0);
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    check("post_rst_pass", rd_data_o, 32'h0000BEEF);
    do_op('{OP_LH, 32'h10, 32'h0, 5'd2, 32'h00001234, 0, 32'h00001234, 5'd2});
    do_op('{OP_LBU, 32'h11, 32'h0, 5'd2, 32'h000000F1, 0, 32'h000000F1, 5'd2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 SHALL have ports clk input 1 (rising-edge clock) and rst input 1; one clock, and reset is synchronous and active-high.
REQ-002 SHALL have rd_data_i input RegLen: ALU result, or store data for SB/SH/SW, from the EX/MEM latch.
REQ-003 SHALL have rd_addr_i input RegAddrLen (destination register) and mem_addr_i input AddrLen (effective address).
REQ-004 SHALL have op_i input OpLen: decoded op code, shared op constants.
REQ-005 SHALL have rd_data_o output RegLen (writeback data) and rd_addr_o output RegAddrLen (writeback register, 0 = none).
REQ-006 SHALL have mem_stall output 1: freezes all earlier pipeline latches while high.
REQ-007 SHALL have mc_req output 1, mc_we output 1, mc_addr output AddrLen and mc_wdata output 8: byte request to the memory controller.
REQ-008 SHALL have mc_ack input 1 (byte accepted/returned this cycle) and mc_rdata input 8 (read byte, valid only with mc_ack).

Function
REQ-009 SHALL implement a state machine with states IDLE, BUSY and DONE, plus a 2-bit byte index idx and a 32-bit load buffer buf.
REQ-010 Byte count n SHALL be 1 for LB/LBU/SB, 2 for LH/LHU/SH, and 4 for LW/SW.
REQ-011 IDLE with a non-memory op SHALL drive rd_data_o=rd_data_i, rd_addr_o=rd_addr_i and mem_stall=0 combinationally (zero-latency pass-through).
REQ-012 IDLE with a load/store op SHALL drive mem_stall=1 combinationally; next edge: BUSY, idx=0, buf=0.
REQ-013 BUSY SHALL drive mc_req=1, mc_addr=mem_addr_i+idx (mod 2^32), mc_we=1 for stores only, mc_wdata=rd_data_i byte idx (little-endian), and mem_stall=1.
REQ-014 mc_req and all mc_* outputs SHALL hold constant in BUSY until mc_ack; the controller may take any number of cycles.
REQ-015 On mc_ack in BUSY, a load SHALL write mc_rdata into buf byte idx.
REQ-016 On mc_ack in BUSY with idx<n-1, idx SHALL increment; with idx==n-1, next state SHALL be DONE.
REQ-017 mc_ack SHALL be ignored outside BUSY.
REQ-018 DONE SHALL drive mem_stall=0 and mc_req=0; next edge: IDLE unconditionally.
REQ-019 In DONE, a load SHALL output rd_addr_o=rd_addr_i and rd_data_o=buf zero-extended (LBU/LHU) or sign-extended from bit 7/15 (LB/LH); LW uses buf unchanged.
REQ-020 In DONE, a store SHALL output rd_addr_o=0 and rd_data_o=0; a store SHALL never write back.
REQ-021 Outside DONE, a memory op SHALL output rd_addr_o=0 and rd_data_o=0.
REQ-022 Inputs SHALL be relied on as stable while mem_stall=1; no input capture beyond buf.
REQ-023 Latency: a memory op with ack on every first request cycle occupies n+2 cycles (IDLE, n×BUSY, DONE); a back-to-back memory op re-enters IDLE then BUSY.
REQ-024 Byte address wrap SHALL be defined: 0xFFFFFFFF+1 = 0x00000000.

Reset
REQ-025 With rst high at an edge, the block SHALL go to IDLE with idx=0 and buf=0, including mid-BUSY; the in-flight access is abandoned.
REQ-026 While rst is high, the block SHALL drive rd_data_o=0, rd_addr_o=0, mem_stall=0, mc_req=0, mc_we=0, mc_addr=0 and mc_wdata=0.

Structure
REQ-027 Op codes, OpLen, RegLen, AddrLen, RegAddrLen, ZERO_WORD, True/False and RegAddrZero SHALL come from the shared config header; state encodings are local to the block.
REQ-028 SHALL be a single module with no sub-module; byte sequencing and extension live inline.

Verification
REQ-029 ADD, rd_data_i=0x12345678, rd_addr_i=5 -> same cycle rd_data_o=0x12345678, rd_addr_o=5, mem_stall=0, mc_req never high.
REQ-030 LB, mem_addr_i=0x100, mc_rdata=0x80 acked after 3 wait cycles -> mc_addr=0x100 held 4 cycles; DONE rd_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-031 LW, mem_addr_i=0x200, bytes 0x78,0x56,0x34,0x12 acked immediately -> mc_addr 0x200..0x203; DONE rd_data_o=0x12345678; mem_stall high exactly 5 cycles.
REQ-032 SH, mem_addr_i=0xFFFFFFFF, rd_data_i=0xABCDBEEF -> writes (0xFFFFFFFF,0xEF) then (0x00000000,0xBE) with mc_we=1; DONE rd_addr_o=0.
REQ-033 LW with rst asserted after the second ack -> next cycle IDLE, mc_req=0, mem_stall=0; a following LH at 0x10 completes correctly with buf starting at 0.
REQ-034 LH at 0x10 immediately followed by SB -> LH DONE output correct; SB begins in the next cycle with no lost or duplicated request.
